pfpu_dmawr: RTL and testbench
=============================

// Module: pfpu_dmawr
// PURPOSE
//  Vertex write-back stage downstream of the PFPU datapath. Takes each VECTOUT
//  result (two 32-bit floats plus a 64-bit-aligned target address), buffers it in a
//  small FIFO and drains it as single-word Wishbone master writes to memory.
//  Also reports its pending-request count to the PFPU diagnostics CSR and its
//  idle state to the completion/IRQ logic.
// PARAMETERS
//  FIFO_AW  2  log2 of FIFO depth in vertex entries (depth = 1<<FIFO_AW, >=1)
// PORTS
//  sys_clk      in   1   system clock, all state on rising edge
//  sys_rst      in   1   reset, asynchronous, active-high
//  dma_en       in   1   push strobe: one vertex result presented this cycle
//  dma_adr      in   29  vertex address bits [31:3]
//  dma_d1       in   32  first word (VECTOUT opA)
//  dma_d2       in   32  second word (VECTOUT opB)
//  dma_busy     out  1   FIFO full; upstream must not assert dma_en
//  dma_pending  out  FIFO_AW+1  entries queued, including the one in flight
//  dma_idle     out  1   FIFO empty and no bus cycle active
//  dma_ovf      out  1   1-cycle pulse: dma_en seen while dma_busy, entry dropped
//  wbm_adr_o    out  32  Wishbone address; bits [1:0] always 0
//  wbm_dat_o    out  32  Wishbone write data
//  wbm_cyc_o    out  1   Wishbone cycle
//  wbm_stb_o    out  1   Wishbone strobe; equal to wbm_cyc_o at all times
//  wbm_ack_i    in   1   Wishbone acknowledge
// BEHAVIOUR
//  - Reset values: wbm_cyc_o=wbm_stb_o=0; wbm_adr_o=wbm_dat_o=0; dma_busy=0;
//    dma_pending=0; dma_idle=1; dma_ovf=0. FIFO pointers cleared.
//  - Push: accepted on an edge with dma_en=1 and dma_busy=0.
//    dma_busy = (dma_pending == 1<<FIFO_AW), decoded from registered count.
//    A push that is rejected for fullness is not retried by a same-cycle pop.
//  - Pending count: +1 per accepted push, -1 on ack of word 2. Both on one edge: unchanged.
//  - FSM states: IDLE, W1, W2. Bus outputs are registered.
//    IDLE: FIFO non-empty -> W1. cyc/stb=1, adr={head.adr,3'b000}, dat=head.d1.
//      First stb is asserted the cycle after the push edge.
//    W1: hold all bus outputs until wbm_ack_i=1. On ack -> W2, with
//      adr={head.adr,3'b100}, dat=head.d2 and stb held high (back-to-back).
//    W2: hold until ack. On ack, pop head. If another entry remains -> W1 with the
//      new head and stb held high. Otherwise -> IDLE and deassert cyc/stb.
//  - wbm_ack_i outside W1/W2 is ignored. Bus outputs never change while stb=1 and
//    ack=0.
//  - Minimum time per vertex is 2 cycles; sustained rate is bounded only by ack.
//  - dma_idle = (state==IDLE) && FIFO empty. It goes low the cycle after the push
//    edge and high the cycle after the final ack.
//  - Reset asserted mid-transfer: cyc/stb drop asynchronously and all queued
//    entries are discarded. This is legal only at system reset.
// STRUCTURE
//  - Shared header pfpu_dmawr.vh holds the FSM state encodings (IDLE/W1/W2) and the
//    entry width (29+32+32 = 93 bits).
//  - Sub-module pfpu_dmafifo: a synchronous FIFO, 93 bits wide x (1<<FIFO_AW) deep,
//    with a registered count, asynchronous active-high reset, and a head entry that
//    is readable without a pop.
//  - The FSM, count/flag logic and Wishbone drive live in pfpu_dmawr.
// TESTING
//  1) Single vertex: adr=29'h0803bc65, d1=3.0f, d2=9.0f, ack on the 2nd stb cycle.
//     Required: writes 401de328=40400000 then 401de32c=41100000; idle returns 1.
//  2) Fill: 4 pushes on consecutive cycles with ack held 0. Required: busy=1 after
//     the 4th push and pending=4. A 5th push gives dma_ovf=1 and is dropped.
//     Releasing ack gives 8 writes in push order.
//  3) Random ack: ack in ~1/3 of cycles, 120 vertices (12x10 mesh). Required: 240
//     writes in order, no repeated or missing address, pending returns to 0.
//  4) Push with pop: FIFO at 3, push on the same edge as the word-2 ack.
//     Required: pending stays 3 and busy stays 0.
//  5) Reset mid-W2: assert sys_rst between edges. Required: cyc/stb drop
//     immediately, pending=0, idle=1. A new push afterwards runs normally.
//  6) Spurious ack while idle. Required: no state change and no pop.

Source files
------------

// File: rtl/pfpu_dmawr_pkg.sv
// Shared types for the PFPU vertex write-back stage: FSM states, FIFO entry layout
// and the Wishbone address builder.
package pfpu_dmawr_pkg;

  localparam int unsigned ADR_W = 29;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned WB_AW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_W1   = 2'd1,
    ST_W2   = 2'd2
  } state_e;

  // One vertex result: 29 + 32 + 32 = 93 bits.
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] d1;
    logic [DAT_W-1:0] d2;
  } entry_t;

  // Byte address of word 0 or word 1 of an 8-byte vertex slot.
  function automatic logic [WB_AW-1:0] wb_addr(input logic [ADR_W-1:0] adr,
                                               input logic             second);
    return {adr, second, 2'b00};
  endfunction

endpackage

// File: rtl/pfpu_dmawr_if.sv
// Push-side and Wishbone master signals of the write-back stage.
interface pfpu_dmawr_if #(
  parameter int unsigned FIFO_AW = 2
);
  logic             dma_en;
  logic [28:0]      dma_adr;
  logic [31:0]      dma_d1;
  logic [31:0]      dma_d2;
  logic             dma_busy;
  logic [FIFO_AW:0] dma_pending;
  logic             dma_idle;
  logic             dma_ovf;

  logic [31:0]      wbm_adr_o;
  logic [31:0]      wbm_dat_o;
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_ack_i;

  modport master (
    input  dma_en, dma_adr, dma_d1, dma_d2, wbm_ack_i,
    output dma_busy, dma_pending, dma_idle, dma_ovf,
           wbm_adr_o, wbm_dat_o, wbm_cyc_o, wbm_stb_o
  );

  modport slave (
    output dma_en, dma_adr, dma_d1, dma_d2, wbm_ack_i,
    input  dma_busy, dma_pending, dma_idle, dma_ovf,
           wbm_adr_o, wbm_dat_o, wbm_cyc_o, wbm_stb_o
  );
endinterface

// File: rtl/pfpu_dmafifo.sv
// Synchronous vertex FIFO with registered count; head and the entry behind it are
// readable without a pop.
module pfpu_dmafifo
  import pfpu_dmawr_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  entry_t           din_i,
  output entry_t           head_o,
  output entry_t           head_next_o,
  output logic [FIFO_AW:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = (FIFO_AW > 0) ? FIFO_AW : 1;
  localparam int unsigned CW    = FIFO_AW + 1;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Fullness comes from the registered count, so a same-edge pop never frees a slot.
  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign push_ok     = push_i && !full_o;
  assign pop_ok      = pop_i && !empty_o;
  assign count_o     = count_q;
  assign head_o      = mem_q[rd_ptr_q];
  assign head_next_o = mem_q[ptr_inc(rd_ptr_q)];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/pfpu_dmawr.sv
// PFPU vertex write-back: queues VECTOUT results and drains each as two
// back-to-back single-word Wishbone writes.
module pfpu_dmawr
  import pfpu_dmawr_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  pfpu_dmawr_if.master     bus
);

  localparam int unsigned CW = FIFO_AW + 1;

  entry_t          push_entry;
  entry_t          fifo_head;
  entry_t          fifo_head_next;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic            push_ok, pop;

  state_e          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic            ovf_q, ovf_d;

  assign push_entry = '{adr: bus.dma_adr, d1: bus.dma_d1, d2: bus.dma_d2};
  assign push_ok    = bus.dma_en && !fifo_full;
  assign pop        = (state_q == ST_W2) && bus.wbm_ack_i;

  pfpu_dmafifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk         (sys_clk),
    .rst         (sys_rst),
    .push_i      (bus.dma_en),
    .pop_i       (pop),
    .din_i       (push_entry),
    .head_o      (fifo_head),
    .head_next_o (fifo_head_next),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Word sequencing; an entry arriving into an empty FIFO is forwarded directly so
  // the first strobe appears right after its push edge.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    ovf_d   = bus.dma_en && fifo_full;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_W1;
          cyc_d   = 1'b1;
          adr_d   = wb_addr(fifo_head.adr, 1'b0);
          dat_d   = fifo_head.d1;
        end else if (push_ok) begin
          state_d = ST_W1;
          cyc_d   = 1'b1;
          adr_d   = wb_addr(push_entry.adr, 1'b0);
          dat_d   = push_entry.d1;
        end
      end
      ST_W1: begin
        if (bus.wbm_ack_i) begin
          state_d = ST_W2;
          adr_d   = wb_addr(fifo_head.adr, 1'b1);
          dat_d   = fifo_head.d2;
        end
      end
      ST_W2: begin
        if (bus.wbm_ack_i) begin
          if (fifo_count > CW'(1)) begin
            state_d = ST_W1;
            adr_d   = wb_addr(fifo_head_next.adr, 1'b0);
            dat_d   = fifo_head_next.d1;
          end else if (push_ok) begin
            state_d = ST_W1;
            adr_d   = wb_addr(push_entry.adr, 1'b0);
            dat_d   = push_entry.d1;
          end else begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.wbm_cyc_o   = cyc_q;
  assign bus.wbm_stb_o   = cyc_q;
  assign bus.wbm_adr_o   = adr_q;
  assign bus.wbm_dat_o   = dat_q;
  assign bus.dma_busy    = fifo_full;
  assign bus.dma_pending = fifo_count;
  assign bus.dma_idle    = (state_q == ST_IDLE) && fifo_empty;
  assign bus.dma_ovf     = ovf_q;

endmodule

// File: tb/tb_pfpu_dmawr.sv
// Directed bench for pfpu_dmawr: acts as upstream pusher and Wishbone slave.
module tb_pfpu_dmawr;

  localparam int unsigned FIFO_AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pfpu_dmawr_if #(.FIFO_AW(FIFO_AW)) bus();

  pfpu_dmawr #(.FIFO_AW(FIFO_AW)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int ack_mode     = 0;   // 0: driven by tests, 1: always high, 2: ~1/3 random
  logic [63:0] wr_log [$];

  always @(negedge clk) begin
    if (ack_mode == 1)      bus.wbm_ack_i = 1'b1;
    else if (ack_mode == 2) bus.wbm_ack_i = ($urandom_range(0, 2) == 0);
  end

  // Record every completed write as {address, data}.
  always @(posedge clk) begin
    if (!rst && bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_ack_i)
      wr_log.push_back({bus.wbm_adr_o, bus.wbm_dat_o});
  end

  task automatic push(input logic [28:0] a, input logic [31:0] d1, input logic [31:0] d2);
    bus.dma_en  = 1'b1;
    bus.dma_adr = a;
    bus.dma_d1  = d1;
    bus.dma_d2  = d2;
    @(negedge clk);
    bus.dma_en  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.dma_idle) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    bus.dma_en = 0; bus.dma_adr = '0; bus.dma_d1 = '0; bus.dma_d2 = '0;
    bus.wbm_ack_i = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.dma_busy, bus.dma_idle, bus.dma_ovf} !== 5'b00010) begin
      tests_failed++;
      $display("FAIL reset_flags: cyc/stb/busy/idle/ovf got %b want 00010",
               {bus.wbm_cyc_o, bus.wbm_stb_o, bus.dma_busy, bus.dma_idle, bus.dma_ovf});
    end
    tests_run++;
    if ({bus.wbm_adr_o, bus.wbm_dat_o, bus.dma_pending} !== 67'h0) begin
      tests_failed++;
      $display("FAIL reset_values: adr %h dat %h pending %0d, want all zero",
               bus.wbm_adr_o, bus.wbm_dat_o, bus.dma_pending);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    ack_mode = 0; bus.wbm_ack_i = 0; wr_log.delete();
    push(29'h0803bc65, 32'h40400000, 32'h41100000);
    tests_run++;
    if ({bus.wbm_stb_o, bus.dma_idle, bus.wbm_adr_o, bus.wbm_dat_o} !== {2'b10, 32'h401de328, 32'h40400000}) begin
      tests_failed++;
      $display("FAIL single_first_stb: stb %b idle %b adr %h dat %h want 1 0 401de328 40400000",
               bus.wbm_stb_o, bus.dma_idle, bus.wbm_adr_o, bus.wbm_dat_o);
    end
    @(negedge clk);
    tests_run++;
    if ({bus.wbm_stb_o, bus.wbm_adr_o, bus.wbm_dat_o} !== {1'b1, 32'h401de328, 32'h40400000}) begin
      tests_failed++;
      $display("FAIL single_hold: stb %b adr %h dat %h want held word 1",
               bus.wbm_stb_o, bus.wbm_adr_o, bus.wbm_dat_o);
    end
    bus.wbm_ack_i = 1;
    @(negedge clk);
    tests_run++;
    if ({bus.wbm_stb_o, bus.wbm_adr_o, bus.wbm_dat_o} !== {1'b1, 32'h401de32c, 32'h41100000}) begin
      tests_failed++;
      $display("FAIL single_word2: stb %b adr %h dat %h want 1 401de32c 41100000",
               bus.wbm_stb_o, bus.wbm_adr_o, bus.wbm_dat_o);
    end
    @(negedge clk);
    bus.wbm_ack_i = 0;
    tests_run++;
    if ({bus.wbm_cyc_o, bus.dma_idle, bus.dma_pending} !== {2'b01, 3'd0}) begin
      tests_failed++;
      $display("FAIL single_done: cyc %b idle %b pending %0d want 0 1 0",
               bus.wbm_cyc_o, bus.dma_idle, bus.dma_pending);
    end
    tests_run++;
    if (wr_log.size() != 2 || wr_log[0] !== 64'h401de328_40400000 || wr_log[1] !== 64'h401de32c_41100000) begin
      tests_failed++;
      $display("FAIL single_log: %0d writes, first %h want 2 writes 401de328_40400000, 401de32c_41100000",
               wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 64'h0);
    end
  endtask

  task automatic test_fill;
    bit ok;
    logic [63:0] exp;
    ack_mode = 0; bus.wbm_ack_i = 0; wr_log.delete();
    for (int i = 0; i < 4; i++) push(29'h100 + 29'(i), 32'hA000_0000 + i, 32'hB000_0000 + i);
    tests_run++;
    if ({bus.dma_busy, bus.dma_pending} !== {1'b1, 3'd4}) begin
      tests_failed++;
      $display("FAIL fill_full: busy %b pending %0d want 1 4", bus.dma_busy, bus.dma_pending);
    end
    push(29'h1FF, 32'hDEAD_0000, 32'hDEAD_0001);
    tests_run++;
    if ({bus.dma_ovf, bus.dma_pending} !== {1'b1, 3'd4}) begin
      tests_failed++;
      $display("FAIL fill_ovf: ovf %b pending %0d want 1 4", bus.dma_ovf, bus.dma_pending);
    end
    @(negedge clk);
    tests_run++;
    if (bus.dma_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_ovf_pulse: ovf %b want 0", bus.dma_ovf);
    end
    ack_mode = 1;
    wait_idle(100, ok);
    ack_mode = 0; bus.wbm_ack_i = 0;
    tests_run++;
    if (ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_drain_timeout: idle %b want 1", bus.dma_idle);
    end
    tests_run++;
    if (wr_log.size() != 8) begin
      tests_failed++;
      $display("FAIL fill_count: %0d writes want 8", wr_log.size());
    end
    for (int k = 0; k < 8 && k < wr_log.size(); k++) begin
      exp = {29'h100 + 29'(k / 2), (k % 2 == 1), 2'b00,
             ((k % 2 == 1) ? 32'hB000_0000 : 32'hA000_0000) + 32'(k / 2)};
      tests_run++;
      if (wr_log[k] !== exp) begin
        tests_failed++;
        $display("FAIL fill_write%0d: got %h want %h", k, wr_log[k], exp);
      end
    end
  endtask

  task automatic test_random_ack;
    bit ok;
    int n, cyc;
    logic [63:0] exp;
    logic [28:0] a;
    wr_log.delete();
    ack_mode = 2;
    n = 0; cyc = 0;
    while (n < 120 && cyc < 5000) begin
      if (!bus.dma_busy) begin
        a = 29'h0040_0000 + 29'((n / 12) * 16 + (n % 12));
        bus.dma_en = 1; bus.dma_adr = a;
        bus.dma_d1 = 32'h3F80_0000 | 32'(n);
        bus.dma_d2 = 32'h4000_0000 | 32'(n);
        n++;
      end else bus.dma_en = 0;
      @(negedge clk);
      cyc++;
    end
    bus.dma_en = 0;
    wait_idle(3000, ok);
    ack_mode = 0; bus.wbm_ack_i = 0;
    tests_run++;
    if (n != 120 || ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL rand_progress: pushed %0d idle %b want 120 1", n, ok);
    end
    tests_run++;
    if (wr_log.size() != 240 || bus.dma_pending !== 3'd0) begin
      tests_failed++;
      $display("FAIL rand_totals: %0d writes pending %0d want 240 0", wr_log.size(), bus.dma_pending);
    end
    for (int k = 0; k < 240 && k < wr_log.size(); k++) begin
      a   = 29'h0040_0000 + 29'(((k / 2) / 12) * 16 + ((k / 2) % 12));
      exp = {a, (k % 2 == 1), 2'b00,
             ((k % 2 == 1) ? 32'h4000_0000 : 32'h3F80_0000) | 32'(k / 2)};
      tests_run++;
      if (wr_log[k] !== exp) begin
        tests_failed++;
        $display("FAIL rand_write%0d: got %h want %h", k, wr_log[k], exp);
      end
    end
  endtask

  task automatic test_push_with_pop;
    bit ok;
    logic [63:0] exp;
    ack_mode = 0; bus.wbm_ack_i = 0; wr_log.delete();
    for (int i = 0; i < 3; i++) push(29'h200 + 29'(i), 32'hC000_0000 + i, 32'hD000_0000 + i);
    tests_run++;
    if ({bus.dma_pending, bus.wbm_adr_o} !== {3'd3, 32'h0000_1000}) begin
      tests_failed++;
      $display("FAIL pp_setup: pending %0d adr %h want 3 00001000", bus.dma_pending, bus.wbm_adr_o);
    end
    bus.wbm_ack_i = 1;
    @(negedge clk);
    push(29'h203, 32'hC000_0003, 32'hD000_0003);
    bus.wbm_ack_i = 0;
    tests_run++;
    if ({bus.dma_pending, bus.dma_busy, bus.wbm_stb_o, bus.wbm_adr_o} !== {3'd3, 2'b01, 32'h0000_1008}) begin
      tests_failed++;
      $display("FAIL pp_same_edge: pending %0d busy %b stb %b adr %h want 3 0 1 00001008",
               bus.dma_pending, bus.dma_busy, bus.wbm_stb_o, bus.wbm_adr_o);
    end
    ack_mode = 1;
    wait_idle(100, ok);
    ack_mode = 0; bus.wbm_ack_i = 0;
    tests_run++;
    if (ok !== 1'b1 || wr_log.size() != 8) begin
      tests_failed++;
      $display("FAIL pp_drain: idle %b writes %0d want 1 8", ok, wr_log.size());
    end
    for (int k = 0; k < 8 && k < wr_log.size(); k++) begin
      exp = {29'h200 + 29'(k / 2), (k % 2 == 1), 2'b00,
             ((k % 2 == 1) ? 32'hD000_0000 : 32'hC000_0000) + 32'(k / 2)};
      tests_run++;
      if (wr_log[k] !== exp) begin
        tests_failed++;
        $display("FAIL pp_write%0d: got %h want %h", k, wr_log[k], exp);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    ack_mode = 0; bus.wbm_ack_i = 0;
    push(29'h300, 32'h1111_1111, 32'h2222_2222);
    push(29'h301, 32'h3333_3333, 32'h4444_4444);
    bus.wbm_ack_i = 1;
    @(negedge clk);
    bus.wbm_ack_i = 0;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.dma_idle, bus.dma_pending} !== {3'b001, 3'd0}) begin
      tests_failed++;
      $display("FAIL rst_mid: cyc %b stb %b idle %b pending %0d want 0 0 1 0",
               bus.wbm_cyc_o, bus.wbm_stb_o, bus.dma_idle, bus.dma_pending);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr_log.delete();
    ack_mode = 1;
    push(29'h310, 32'h5555_5555, 32'h6666_6666);
    wait_idle(50, ok);
    ack_mode = 0; bus.wbm_ack_i = 0;
    tests_run++;
    if (ok !== 1'b1 || wr_log.size() != 2 || wr_log[0] !== 64'h0000_1880_5555_5555 ||
        wr_log[1] !== 64'h0000_1884_6666_6666) begin
      tests_failed++;
      $display("FAIL rst_after: idle %b writes %0d first %h want 1 2 00001880_55555555",
               ok, wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 64'h0);
    end
  endtask

  task automatic test_spurious_ack;
    bit ok;
    ack_mode = 0; bus.wbm_ack_i = 1; wr_log.delete();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.dma_idle, bus.wbm_cyc_o, bus.dma_pending} !== {2'b10, 3'd0} || wr_log.size() != 0) begin
      tests_failed++;
      $display("FAIL spur_idle: idle %b cyc %b pending %0d writes %0d want 1 0 0 0",
               bus.dma_idle, bus.wbm_cyc_o, bus.dma_pending, wr_log.size());
    end
    push(29'h3A0, 32'h7777_7777, 32'h8888_8888);
    wait_idle(20, ok);
    bus.wbm_ack_i = 0;
    tests_run++;
    if (ok !== 1'b1 || wr_log.size() != 2 || wr_log[0] !== 64'h0000_1D00_7777_7777 ||
        wr_log[1] !== 64'h0000_1D04_8888_8888) begin
      tests_failed++;
      $display("FAIL spur_then_push: idle %b writes %0d first %h want 1 2 00001d00_77777777",
               ok, wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 64'h0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_random_ack();
    test_push_with_pop();
    test_reset_mid();
    test_spurious_ack();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
